mem_stage_buf: RTL
==================

MEM_STAGE_BUF -- requirements
Module: mem_stage_buf

Interface
REQ-001 Parameter DW, default 16, data width in bits.
REQ-002 Parameter AW, default 16, address width in bits.
REQ-003 Parameter SB_DEPTH, default 4, store-buffer entries; power of 2, at least 2.
REQ-004 Port clk, in, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, in, 1: synchronous, active-high reset.
REQ-006 Port req_valid, in, 1: pipeline presents a memory op.
REQ-007 Ports req_rd and req_wr, in, 1 each: load and store select.
REQ-008 Ports req_addr, in, AW, and req_wdata, in, DW: op address and store data.
REQ-009 Port dump, in, 1: halt/dump request from the pipeline.
REQ-010 Port req_ready, out, 1: op accepted this cycle.
REQ-011 Port stall, out, 1: equals req_valid & ~req_ready.
REQ-012 Ports rsp_valid, out, 1, and rsp_rdata, out, DW: load result.
REQ-013 Ports mem_rd and mem_wr, out, 1 each; mem_addr, out, AW; mem_wdata, out, DW: data-memory request.
REQ-014 Ports mem_rdata, in, DW; mem_done, in, 1; mem_err, in, 1: data-memory response.
REQ-015 Port sb_count, out, clog2(SB_DEPTH+1): current store-buffer occupancy.
REQ-016 Port err, out, 1, and halt, out, 1: sticky error flag and processor halt.

Function
REQ-017 FSM states: IDLE, LOAD, DRAIN, HALTED; at most one memory op outstanding.
REQ-018 Store acceptance: when req_valid & req_wr and buffer not full, req_ready=1 in the same cycle and the entry is pushed at the clock edge.
REQ-019 Store with buffer full: req_ready=0 and no push; a same-cycle pop does not free the slot for that cycle's store.
REQ-020 req_rd and req_wr both high: op treated as a store; req_rd is ignored.
REQ-021 Load forward hit: buffer holds a matching address; req_ready=1 and rsp_valid=1 in the same cycle; rsp_rdata is the youngest matching entry's data.
REQ-022 Load miss in IDLE: next state LOAD; registered mem_rd=1 with mem_addr=req_addr from the next cycle, held stable until mem_done.
REQ-023 In LOAD, in the cycle mem_done=1: rsp_valid=1, req_ready=1, rsp_rdata=mem_rdata combinationally; next state IDLE.
REQ-024 Load priority: a pending load miss takes priority over draining; loads bypass non-matching buffered stores.
REQ-025 Drain: in IDLE with buffer non-empty and no load miss pending, next state DRAIN; mem_wr=1 with the head entry's address and data, held until mem_done.
REQ-026 On mem_done in DRAIN: head popped; next state IDLE.
REQ-027 Buffer pointers wrap modulo SB_DEPTH; a push and a pop in the same cycle leave sb_count unchanged.
REQ-028 mem_err high during any op: err set (sticky), buffer frozen, next state HALTED.
REQ-029 dump accepted (req_valid & dump): no new ops accepted; HALTED is entered once the buffer is empty and the FSM is IDLE.
REQ-030 halt=1 exactly while in HALTED; HALTED is left only by rst.
REQ-031 rsp_valid is a 1-cycle pulse per completed load; mem_rd and mem_wr are never high simultaneously.

Reset
REQ-032 rst: FSM to IDLE, pointers and sb_count to 0, err=0.
REQ-033 While rst is high, all outputs are 0 (req_ready, stall, rsp_valid, rsp_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, halt).
REQ-034 rst during LOAD or DRAIN abandons the in-flight op: mem_rd and mem_wr are 0 in the cycle after the reset edge, and buffered stores are discarded.

Configuration
REQ-035 Macro MEM_STAGE_STORE_FWD_EN defined: store-to-load forwarding (REQ-021) and load bypass (REQ-024) are compiled in.
REQ-036 Macro undefined: every load waits in IDLE with req_ready=0 until the buffer is empty, then issues to memory; forwarding logic is absent.

Verification
REQ-037 Four stores (A=0x0010..0x0016, data 0x1111..0x4444) with mem_done fixed 2 cycles after each request -> sb_count reaches 4; 5th store stalls; stores drain to memory in order; sb_count ends at 0.
REQ-038 Store 0x0020<-0xBEEF then 0x0020<-0xCAFE, then load 0x0020 with mem stalled -> rsp_valid and rsp_rdata=0xCAFE in the same cycle, no mem_rd (FWD_EN defined); with the macro undefined, the load completes only after both stores drain.
REQ-039 Load 0x0030 with buffer non-empty, mem_rdata=0x5A5A -> mem_rd is issued before the next mem_wr; rsp_rdata=0x5A5A on the mem_done cycle.
REQ-040 mem_err pulsed during a drain -> err=1, halt=1 next cycle, all later requests see stall=1 until rst.
REQ-041 dump with 3 buffered stores -> halt stays 0 until the 3rd mem_done, then halt=1; rst asserted mid-DRAIN -> mem_wr=0 and sb_count=0 in the cycle after the edge.

Source files
------------

// File: rtl/mem_stage_buf.sv
// Memory-stage store buffer with a single-outstanding-op FSM. Store-to-load forwarding and
// load bypass are compiled in only when MEM_STAGE_STORE_FWD_EN is defined.
module mem_stage_buf #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int SB_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    input  logic                            req_rd,
    input  logic                            req_wr,
    input  logic [AW-1:0]                   req_addr,
    input  logic [DW-1:0]                   req_wdata,
    input  logic                            dump,
    output logic                            req_ready,
    output logic                            stall,
    output logic                            rsp_valid,
    output logic [DW-1:0]                   rsp_rdata,
    output logic                            mem_rd,
    output logic                            mem_wr,
    output logic [AW-1:0]                   mem_addr,
    output logic [DW-1:0]                   mem_wdata,
    input  logic [DW-1:0]                   mem_rdata,
    input  logic                            mem_done,
    input  logic                            mem_err,
    output logic [$clog2(SB_DEPTH+1)-1:0]   sb_count,
    output logic                            err,
    output logic                            halt
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);

    // IDLE: pick next op | LOAD: read outstanding | DRAIN: head store outstanding | HALTED: until rst
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   sb_addr_q [SB_DEPTH];
    logic [DW-1:0]   sb_data_q [SB_DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic            err_q, err_d, dump_q, dump_d;
    logic            mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            push, pop, req_ready_c, rsp_valid_c;
    logic [DW-1:0]   rsp_rdata_c;
    logic            full, empty, active, is_st, is_ld, dump_req, fault, load_go;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign active   = (state_q != HALTED) && !dump_q && !rst;
    assign dump_req = req_valid & dump & active;
    assign is_st    = req_valid & req_wr & ~dump & active;
    assign is_ld    = req_valid & req_rd & ~req_wr & ~dump & active;
    assign fault    = mem_err & ((state_q == LOAD) | (state_q == DRAIN));

`ifdef MEM_STAGE_STORE_FWD_EN
    logic            fwd_hit, load_hit;
    logic [DW-1:0]   fwd_data;

    // Scan oldest to youngest so the last match is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (sb_addr_q[idx] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[idx];
            end
        end
    end

    assign load_hit = is_ld & fwd_hit & ((state_q == IDLE) | (state_q == DRAIN));
    assign load_go  = is_ld & ~fwd_hit;
`else
    assign load_go  = is_ld & empty;
`endif

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        dump_d      = dump_q | dump_req;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        push        = 1'b0;
        pop         = 1'b0;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        rsp_rdata_c = '0;

        // Full is judged on the registered count: a same-cycle pop never frees the slot.
        if (is_st && !full && !fault) begin
            push        = 1'b1;
            req_ready_c = 1'b1;
        end
        if (dump_req) begin
            req_ready_c = 1'b1;
        end
`ifdef MEM_STAGE_STORE_FWD_EN
        if (load_hit) begin
            req_ready_c = 1'b1;
            rsp_valid_c = 1'b1;
            rsp_rdata_c = fwd_data;
        end
`endif

        case (state_q)
            IDLE: begin
                if (load_go) begin
                    state_d    = LOAD;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = req_addr;
                end else if (!empty) begin
                    state_d     = DRAIN;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = sb_addr_q[head_q];
                    mem_wdata_d = sb_data_q[head_q];
                end else if (dump_d) begin
                    state_d = HALTED;
                end
            end
            LOAD: begin
                if (mem_err) begin
                    err_d    = 1'b1;
                    mem_rd_d = 1'b0;
                    state_d  = HALTED;
                end else if (mem_done) begin
                    mem_rd_d    = 1'b0;
                    state_d     = IDLE;
                    req_ready_c = 1'b1;
                    rsp_valid_c = 1'b1;
                    rsp_rdata_c = mem_rdata;
                end
            end
            DRAIN: begin
                if (mem_err) begin
                    err_d    = 1'b1;
                    mem_wr_d = 1'b0;
                    state_d  = HALTED;
                end else if (mem_done) begin
                    pop      = 1'b1;
                    mem_wr_d = 1'b0;
                    state_d  = (dump_d && (count_q == CW'(1)) && !push) ? HALTED : IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            dump_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            dump_q      <= dump_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            sb_addr_q[tail_q] <= req_addr;
            sb_data_q[tail_q] <= req_wdata;
        end
    end

    assign req_ready = req_ready_c & ~rst;
    assign stall     = req_valid & ~req_ready & ~rst;
    assign rsp_valid = rsp_valid_c & ~rst;
    assign rsp_rdata = rst ? '0 : rsp_rdata_c;
    assign mem_rd    = mem_rd_q & ~rst;
    assign mem_wr    = mem_wr_q & ~rst;
    assign mem_addr  = rst ? '0 : mem_addr_q;
    assign mem_wdata = rst ? '0 : mem_wdata_q;
    assign halt      = (state_q == HALTED) & ~rst;
    assign err       = err_q;
    assign sb_count  = count_q;
endmodule
